cpu_stall_core: RTL and testbench

//  Parametrised successor of the single-cycle 8-bit lab CPU. Adds j/beq/bne, register-indirect and direct load/store,
//  and a busywait-stalled data-memory port. Owns PC, register file, ALU, decode and a 2-state exec/mem FSM.

---
 rtl/cpu_stall_core_pkg.sv | 31 +++
 rtl/cpu_stall_core_reg_file.sv | 41 ++++
 rtl/cpu_stall_core.sv | 159 +++++++++++++++
 tb/tb_cpu_stall_core.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_stall_core_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: opcodes, FSM state type and PC step for cpu_stall_core.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_BNE   = 8'd8;
  localparam logic [7:0] OP_LWD   = 8'd9;
  localparam logic [7:0] OP_LWI   = 8'd10;
  localparam logic [7:0] OP_SWD   = 8'd11;
  localparam logic [7:0] OP_SWI   = 8'd12;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [0:0] {
    ST_EXEC     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cpu_stall_core_reg_file.sv
// ---------------------------------------------------------------------------
// reg_file_p: 2 async read ports, 1 sync write port, sync active-low clear. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_file_p #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0]     rdata_a_o,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]     rdata_b_o
);

  localparam int NREG = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];

  // Reads are not bypassed: a same-cycle write is seen only after the edge.
  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_stall_core.sv
// ---------------------------------------------------------------------------
// cpu_stall_core: single-issue core with exec/mem-wait FSM and busywait-stalled data port. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_stall_core
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int PC_W       = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  output logic [PC_W-1:0]   PC,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [DATA_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              STALL,
  output logic              ILLEGAL
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                illegal_q, illegal_d;

  logic [7:0]            op;
  logic [7:0]            off;
  logic [DATA_W-1:0]     imm_ext;
  logic [REG_ADDR_W-1:0] dst_idx, rt_idx, rs_idx;
  logic [DATA_W-1:0]     rt_val, rs_val, diff;
  logic                  zero;
  logic [PC_W-1:0]       pc_plus4, branch_tgt;
  logic                  rf_we;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  unused_instr_bits;

  assign op      = INSTRUCTION[31:24];
  assign off     = INSTRUCTION[23:16];
  assign imm_ext = DATA_W'(INSTRUCTION[7:0]);
  assign dst_idx = INSTRUCTION[16 +: REG_ADDR_W];
  assign rt_idx  = INSTRUCTION[8 +: REG_ADDR_W];
  assign rs_idx  = INSTRUCTION[0 +: REG_ADDR_W];
  assign unused_instr_bits = ^INSTRUCTION;

  reg_file_p #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rf (
    .clk_i     (CLK),
    .rst_ni    (RESET),
    .we_i      (rf_we),
    .waddr_i   (dst_idx),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rt_idx),
    .rdata_a_o (rt_val),
    .raddr_b_i (rs_idx),
    .rdata_b_o (rs_val)
  );

  assign diff       = rt_val - rs_val;
  assign zero       = (diff == '0);
  assign pc_plus4   = pc_q + PC_W'(PC_INC);
  assign branch_tgt = pc_plus4 + ({{(PC_W-8){off[7]}}, off} << 2);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    illegal_d   = 1'b0;
    rf_we       = 1'b0;
    rf_wdata    = diff;

    case (state_q)
      ST_EXEC: begin
        pc_d = pc_plus4;
        case (op)
          OP_LOADI: begin rf_we = 1'b1; rf_wdata = imm_ext;         end
          OP_MOV:   begin rf_we = 1'b1; rf_wdata = rs_val;          end
          OP_ADD:   begin rf_we = 1'b1; rf_wdata = rt_val + rs_val; end
          OP_SUB:   begin rf_we = 1'b1; rf_wdata = diff;            end
          OP_AND:   begin rf_we = 1'b1; rf_wdata = rt_val & rs_val; end
          OP_OR:    begin rf_we = 1'b1; rf_wdata = rt_val | rs_val; end
          OP_J:     pc_d = branch_tgt;
          OP_BEQ:   if (zero)  pc_d = branch_tgt;
          OP_BNE:   if (!zero) pc_d = branch_tgt;
          OP_LWD, OP_LWI: begin
            mem_read_d = 1'b1;
            mem_addr_d = (op == OP_LWD) ? rs_val : imm_ext;
            pc_d       = pc_q;
            state_d    = ST_MEM_WAIT;
          end
          OP_SWD, OP_SWI: begin
            mem_write_d = 1'b1;
            mem_addr_d  = (op == OP_SWD) ? rs_val : imm_ext;
            mem_wdata_d = rt_val;
            pc_d        = pc_q;
            state_d     = ST_MEM_WAIT;
          end
          default:  illegal_d = 1'b1;
        endcase
      end
      ST_MEM_WAIT: begin
        // INSTRUCTION is still valid here because PC has not moved.
        if (!MEM_BUSYWAIT) begin
          rf_we       = mem_read_q;
          rf_wdata    = MEM_READDATA;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          pc_d        = pc_plus4;
          state_d     = ST_EXEC;
        end
      end
      default: state_d = ST_EXEC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_EXEC;
      pc_q        <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      illegal_q   <= illegal_d;
    end
  end

  assign PC            = pc_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign STALL         = (state_q == ST_MEM_WAIT);
  assign ILLEGAL       = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_stall_core.sv
// ---------------------------------------------------------------------------
// tb_cpu_stall_core: directed and random instruction checks against an ISA-level model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_stall_core;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic        MEM_READ, MEM_WRITE, STALL, ILLEGAL, MEM_BUSYWAIT;
  logic [7:0]  MEM_ADDRESS, MEM_WRITEDATA, MEM_READDATA;

  logic [31:0] PC16;
  logic        MEM_READ16, MEM_WRITE16, STALL16, ILLEGAL16, MEM_BUSYWAIT16;
  logic [15:0] MEM_ADDRESS16, MEM_WRITEDATA16, MEM_READDATA16;

  always #5 CLK = ~CLK;

  cpu_stall_core #(.DATA_W(8), .REG_ADDR_W(3), .PC_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .PC(PC),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .STALL(STALL), .ILLEGAL(ILLEGAL)
  );

  cpu_stall_core #(.DATA_W(16), .REG_ADDR_W(3), .PC_W(32)) dut16 (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .PC(PC16),
    .MEM_READ(MEM_READ16), .MEM_WRITE(MEM_WRITE16), .MEM_ADDRESS(MEM_ADDRESS16),
    .MEM_WRITEDATA(MEM_WRITEDATA16), .MEM_READDATA(MEM_READDATA16),
    .MEM_BUSYWAIT(MEM_BUSYWAIT16), .STALL(STALL16), .ILLEGAL(ILLEGAL16)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          wait_left = 0;
  logic [7:0]  tbmem [256];
  int          m_reg [8];
  int          m_mem [256];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc(input int op, input int dst, input int rt, input int rs);
    logic [7:0] a, b, c, d;
    a = op[7:0]; b = dst[7:0]; c = rt[7:0]; d = rs[7:0];
    return {a, b, c, d};
  endfunction

  // Memory device: raises busywait in the strobe's first cycle for wait_left cycles.
  task automatic tick();
    if (MEM_READ === 1'b1 || MEM_WRITE === 1'b1) begin
      MEM_BUSYWAIT = (wait_left != 0);
      MEM_READDATA = tbmem[MEM_ADDRESS];
      if (wait_left != 0) wait_left--;
      else if (MEM_WRITE) tbmem[MEM_ADDRESS] = MEM_WRITEDATA;
    end else begin
      MEM_BUSYWAIT = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    wait_left = 0;
    m_pc = '0;
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
  endtask

  // ISA-level reference: one instruction's effect on architectural state.
  task automatic model_exec(input logic [31:0] ins, input int lat,
                            output int cyc, output bit ill, output int st_addr);
    int op, d, t, s, imm, o, a, b;
    logic [31:0] nxt;
    op = ins[31:24]; d = ins[23:16] % 8; t = ins[15:8] % 8; s = ins[7:0] % 8;
    imm = ins[7:0]; o = ins[23:16];
    if (o > 127) o -= 256;
    a = m_reg[t]; b = m_reg[s];
    cyc = 1; ill = 1'b0; st_addr = -1;
    nxt = m_pc + 32'd4;
    case (op)
      0:  m_reg[d] = imm;
      1:  m_reg[d] = b;
      2:  m_reg[d] = (a + b) & 255;
      3:  m_reg[d] = (a - b) & 255;
      4:  m_reg[d] = a & b;
      5:  m_reg[d] = a | b;
      6:  nxt = nxt + 32'(o * 4);
      7:  if (a == b) nxt = nxt + 32'(o * 4);
      8:  if (a != b) nxt = nxt + 32'(o * 4);
      9:  begin m_reg[d] = m_mem[b];   cyc = 2 + lat; end
      10: begin m_reg[d] = m_mem[imm]; cyc = 2 + lat; end
      11: begin m_mem[b] = a;   st_addr = b;   cyc = 2 + lat; end
      12: begin m_mem[imm] = a; st_addr = imm; cyc = 2 + lat; end
      default: ill = 1'b1;
    endcase
    m_pc = nxt;
  endtask

  task automatic check_arch(input string tag);
    for (int i = 0; i < 8; i++) check({tag, " reg"}, 32'(dut.u_rf.regs_q[i]), 32'(m_reg[i]));
    check({tag, " pc"}, PC, m_pc);
  endtask

  task automatic run(input logic [31:0] ins, input int lat, input string tag);
    int exp_cyc, cyc, st_addr;
    bit exp_ill;
    INSTRUCTION = ins;
    wait_left = lat;
    model_exec(ins, lat, exp_cyc, exp_ill, st_addr);
    cyc = 0;
    tick();
    cyc++;
    while (STALL !== 1'b0 && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " illegal"}, 32'(ILLEGAL), 32'(exp_ill));
    check({tag, " strobes"}, {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
    check_arch(tag);
    if (st_addr >= 0) check({tag, " mem"}, 32'(tbmem[st_addr]), 32'(m_mem[st_addr]));
  endtask

  initial begin
    int op_r;
    logic [31:0] exp_pc;
    int cyc_d;
    bit ill_d;
    int st_d;

    RESET = 1'b1;
    INSTRUCTION = enc(0, 0, 0, 0);
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = '0;
    MEM_BUSYWAIT16 = 1'b0;
    MEM_READDATA16 = '0;
    for (int i = 0; i < 256; i++) begin
      tbmem[i] = 8'($urandom_range(0, 255));
      m_mem[i] = tbmem[i];
    end

    // Reset state
    do_reset();
    check("reset pc", PC, 32'd0);
    check("reset strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
    check("reset addr/data", {MEM_ADDRESS, MEM_WRITEDATA}, 16'd0);
    check("reset stall/illegal", {30'd0, STALL, ILLEGAL}, 32'd0);
    check_arch("reset");

    // Reset in the middle of a long lwd wait
    run(enc(0, 2, 0, 3), 0, "pre-lwd loadi");
    INSTRUCTION = enc(9, 6, 0, 2);
    wait_left = 6;
    tick();
    check("lwd enters wait", 32'(STALL), 32'd1);
    tick();
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    wait_left = 0;
    m_pc = '0;
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    check("midwait reset pc", PC, 32'd0);
    check("midwait reset read", 32'(MEM_READ), 32'd0);
    check("midwait reset stall", 32'(STALL), 32'd0);
    check_arch("midwait reset");

    // ALU program, also run on the 16-bit core
    do_reset();
    run(enc(0, 1, 0, 5), 0, "loadi r1");
    run(enc(0, 2, 0, 3), 0, "loadi r2");
    run(enc(3, 3, 1, 2), 0, "sub r3");
    run(enc(2, 4, 2, 2), 0, "add r4");
    check("prog pc", PC, 32'd16);
    check("prog r3", 32'(dut.u_rf.regs_q[3]), 32'd2);
    check("prog r4", 32'(dut.u_rf.regs_q[4]), 32'd6);
    run(enc(3, 5, 2, 1), 0, "sub r5");
    check("prog r5 wrap", 32'(dut.u_rf.regs_q[5]), 32'h0FE);
    check("w16 r3", 32'(dut16.u_rf.regs_q[3]), 32'd2);
    check("w16 r4", 32'(dut16.u_rf.regs_q[4]), 32'd6);
    check("w16 r5 wrap", 32'(dut16.u_rf.regs_q[5]), 32'h0000FFFE);
    check("w16 pc", PC16, 32'd20);

    // Branches
    do_reset();
    run(enc(6, 8'h02, 0, 0), 0, "j fwd");
    check("j target", PC, 32'd12);
    run(enc(7, 8'hFE, 1, 1), 0, "beq back1");
    check("beq from 12", PC, 32'd8);
    run(enc(7, 8'hFE, 1, 1), 0, "beq back2");
    check("beq from 8", PC, 32'd4);
    run(enc(6, 8'h00, 0, 0), 0, "j zero");
    run(enc(8, 8'hFE, 1, 1), 0, "bne not taken");
    check("bne from 8", PC, 32'd12);

    // Store with 3 busy cycles
    run(enc(0, 1, 0, 5), 0, "loadi r1=5");
    INSTRUCTION = enc(12, 0, 1, 8'h20);
    wait_left = 3;
    exp_pc = m_pc;
    model_exec(INSTRUCTION, 3, cyc_d, ill_d, st_d);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("swi write", 32'(MEM_WRITE), 32'd1);
      check("swi addr", 32'(MEM_ADDRESS), 32'h20);
      check("swi data", 32'(MEM_WRITEDATA), 32'd5);
      check("swi pc frozen", PC, exp_pc);
    end
    tick();
    check("swi done write", 32'(MEM_WRITE), 32'd0);
    check("swi done pc", PC, exp_pc + 32'd4);
    check("swi mem", 32'(tbmem[8'h20]), 32'd5);

    // Zero-wait load
    tbmem[3] = 8'hA5;
    m_mem[3] = 8'hA5;
    run(enc(0, 2, 0, 3), 0, "loadi r2=3");
    INSTRUCTION = enc(9, 6, 0, 2);
    wait_left = 0;
    model_exec(INSTRUCTION, 0, cyc_d, ill_d, st_d);
    tick();
    check("lwd stall c1", 32'(STALL), 32'd1);
    tick();
    check("lwd stall c2", 32'(STALL), 32'd0);
    check("lwd r6", 32'(dut.u_rf.regs_q[6]), 32'hA5);
    check_arch("lwd");

    // Undefined opcode
    run(enc(8'hFF, 1, 2, 3), 0, "illegal op");
    run(enc(0, 7, 0, 9), 0, "after illegal");

    // Random instruction stream against the ISA model
    for (int n = 0; n < 150; n++) begin
      op_r = $urandom_range(0, 15);
      if (op_r == 15) op_r = 255;
      run(enc(op_r, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)),
          $urandom_range(0, 3), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
